control_escaneo_teclado: RTL and testbench

// Scan controller for the 4x4 hex keypad interface. Drives one-hot column strobes and parks on a column while
// a row is active, giving deteccion_tecla time to debounce. On key_detect_i, latches row/column, encodes the
// hex value and presents it on a valid/ready port to downstream logic. Waits for release (inhibit_i low) before

---
 rtl/control_escaneo_teclado_if.sv | 11 +
 rtl/control_escaneo_teclado.sv | 149 ++++++++++++++
 tb/tb_control_escaneo_teclado.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_escaneo_teclado_if.sv
// Key-code delivery port: the scan controller presents a hex code under valid/ready
// and flags codes it had to drop while the holding register was still full.
interface control_escaneo_teclado_if;
  logic [3:0] codigo;
  logic       valid;
  logic       ready;
  logic       overrun;

  modport master (output codigo, output valid, output overrun, input ready);
  modport slave  (input codigo, input valid, input overrun, output ready);
endinterface

// File: rtl/control_escaneo_teclado.sv
// 4x4 hex keypad scan controller: strobes columns, parks on a column while a row is active,
// captures and encodes the pressed key on key_detect_i and waits for release before rescanning.
//
// state   | meaning
// SCAN    | stepping columns every SCAN_DIV cycles while no row is active
// CAPTURE | one cycle: encode row/column of the detected key
// HOLD    | column frozen until the key is released
module control_escaneo_teclado #(
  parameter int SCAN_DIV = 10_000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [3:0]                   filas_i,
  input  logic                         key_detect_i,
  input  logic                         inhibit_i,
  output logic [3:0]                   columnas_o,
  control_escaneo_teclado_if.master    cod
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       col_idx;
  logic [DIV_W-1:0] div;
  logic [3:0]       filas_m;
  logic [3:0]       filas_s;
  logic             load_pend;
  logic [3:0]       code_pend;

  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic fila_onehot(input logic [3:0] f);
    return (f == 4'b0001) || (f == 4'b0010) || (f == 4'b0100) || (f == 4'b1000);
  endfunction

  // Keypad legend, row-major: {1,2,3,A},{4,5,6,B},{7,8,9,C},{E,0,F,D}.
  function automatic logic [3:0] map_code(input logic [3:0] f, input logic [1:0] col);
    logic [1:0] row;
    logic [3:0] code;
    row = 2'd0;
    unique case (f)
      4'b0010: row = 2'd1;
      4'b0100: row = 2'd2;
      4'b1000: row = 2'd3;
      default: row = 2'd0;
    endcase
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      div         <= '0;
      columnas_o  <= 4'b0001;
      filas_m     <= 4'b0000;
      filas_s     <= 4'b0000;
      load_pend   <= 1'b0;
      code_pend   <= 4'h0;
      cod.codigo  <= 4'h0;
      cod.valid   <= 1'b0;
      cod.overrun <= 1'b0;
    end else begin
      filas_m   <= filas_i;
      filas_s   <= filas_m;
      load_pend <= 1'b0;

      case (state)
        SCAN: begin
          // A detect wins over a column step landing on the same edge.
          if (key_detect_i) begin
            state <= CAPTURE;
          end else if (filas_s == 4'b0000) begin
            if (div == DIV_LAST) begin
              div        <= '0;
              col_idx    <= col_idx + 2'd1;
              columnas_o <= col_onehot(col_idx + 2'd1);
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        CAPTURE: begin
          // Zero or multi-row readings are ambiguous and produce no code.
          if (fila_onehot(filas_s)) begin
            load_pend <= 1'b1;
            code_pend <= map_code(filas_s, col_idx);
          end
          state <= HOLD;
        end
        HOLD: begin
          if (!inhibit_i && !key_detect_i) begin
            state      <= SCAN;
            div        <= '0;
            col_idx    <= col_idx + 2'd1;
            columnas_o <= col_onehot(col_idx + 2'd1);
          end
        end
        default: begin
          state      <= SCAN;
          div        <= '0;
          col_idx    <= 2'd0;
          columnas_o <= 4'b0001;
        end
      endcase

      // Holding register: a pending code is lost only if the previous one is still unread.
      if (load_pend) begin
        if (!cod.valid || cod.ready) begin
          cod.codigo <= code_pend;
          cod.valid  <= 1'b1;
        end else begin
          cod.overrun <= 1'b1;
        end
      end else if (cod.valid && cod.ready) begin
        cod.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_escaneo_teclado.sv
// Directed bench for the keypad scan controller with a short scan period.
module tb_control_escaneo_teclado;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] filas_i = 4'b0000;
  logic       key_detect_i = 1'b0;
  logic       inhibit_i = 1'b0;
  logic [3:0] columnas_o;

  int checks = 0;
  int errors = 0;

  control_escaneo_teclado_if bus ();

  control_escaneo_teclado #(.SCAN_DIV(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .filas_i      (filas_i),
    .key_detect_i (key_detect_i),
    .inhibit_i    (inhibit_i),
    .columnas_o   (columnas_o),
    .cod          (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Waits for columnas_o to step onto the requested column (a fresh arrival, so div is 0).
  task automatic wait_col(input int col);
    logic [3:0] target;
    logic [3:0] prev;
    bit found;
    target = 4'(1 << col);
    prev   = columnas_o;
    found  = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick(1);
      if (columnas_o == target && prev != target) found = 1;
      prev = columnas_o;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_col: columnas_o=%b never reached %b", columnas_o, target);
    end
  endtask

  // Presses a key on the given column; returns right after the edge that loads the code.
  task automatic press(input logic [3:0] row, input int col, input logic rdy_load);
    logic [3:0] exp_col;
    exp_col = 4'(1 << col);
    wait_col(col);
    filas_i = row;
    tick(3);
    key_detect_i = 1'b1;
    inhibit_i    = 1'b1;
    tick(1);
    key_detect_i = 1'b0;
    tick(1);
    if (rdy_load) bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    checks++;
    if (columnas_o !== exp_col) begin
      errors++;
      $display("FAIL press_col_frozen: columnas_o=%b expected %b", columnas_o, exp_col);
    end
  endtask

  task automatic release_key();
    filas_i   = 4'b0000;
    inhibit_i = 1'b0;
    tick(1);
  endtask

  task automatic consume();
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    checks++;
    if (columnas_o !== 4'b0001 || bus.valid !== 1'b0 || bus.codigo !== 4'h0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: col=%b valid=%b code=%h ovr=%b expected 0001 0 0 0",
               columnas_o, bus.valid, bus.codigo, bus.overrun);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp = 4'(1 << ((i / 4) % 4));
      checks++;
      if (columnas_o !== exp) begin
        errors++;
        $display("FAIL scan_step%0d: columnas_o=%b expected %b", i, columnas_o, exp);
      end
    end
  endtask

  task automatic test_key_latency();
    wait_col(2);
    filas_i = 4'b0010;
    tick(3);
    key_detect_i = 1'b1;
    inhibit_i    = 1'b1;
    tick(1);
    key_detect_i = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || columnas_o !== 4'b0100) begin
      errors++;
      $display("FAIL lat_n: valid=%b col=%b expected 0 0100", bus.valid, columnas_o);
    end
    tick(1);
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_n1: valid=%b expected 0", bus.valid);
    end
    tick(1);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h6 || columnas_o !== 4'b0100) begin
      errors++;
      $display("FAIL key6: valid=%b code=%h col=%b expected 1 6 0100", bus.valid, bus.codigo, columnas_o);
    end
    release_key();
    checks++;
    if (columnas_o !== 4'b1000) begin
      errors++;
      $display("FAIL release_next_col: columnas_o=%b expected 1000", columnas_o);
    end
    consume();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL consume6: valid=%b expected 0", bus.valid);
    end
  endtask

  task automatic test_overrun();
    press(4'b0010, 1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h5 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL key5: valid=%b code=%h ovr=%b expected 1 5 0", bus.valid, bus.codigo, bus.overrun);
    end
    release_key();
    press(4'b0001, 3, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h5 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_A: valid=%b code=%h ovr=%b expected 1 5 1", bus.valid, bus.codigo, bus.overrun);
    end
    release_key();
    consume();
    checks++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b expected 0 1", bus.valid, bus.overrun);
    end
  endtask

  task automatic test_multi_row();
    press(4'b0011, 0, 1'b0);
    checks++;
    if (bus.valid !== 1'b0 || bus.codigo !== 4'h5) begin
      errors++;
      $display("FAIL multi_row: valid=%b code=%h expected 0 5", bus.valid, bus.codigo);
    end
    release_key();
    checks++;
    if (columnas_o !== 4'b0010) begin
      errors++;
      $display("FAIL multi_row_resume: columnas_o=%b expected 0010", columnas_o);
    end
  endtask

  task automatic test_reset_in_hold();
    press(4'b0001, 2, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h3) begin
      errors++;
      $display("FAIL hold_key3: valid=%b code=%h expected 1 3", bus.valid, bus.codigo);
    end
    reset_i   = 1'b1;
    filas_i   = 4'b0000;
    inhibit_i = 1'b0;
    tick(1);
    reset_i = 1'b0;
    checks++;
    if (columnas_o !== 4'b0001 || bus.valid !== 1'b0 || bus.overrun !== 1'b0 || bus.codigo !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold: col=%b valid=%b ovr=%b code=%h expected 0001 0 0 0",
               columnas_o, bus.valid, bus.overrun, bus.codigo);
    end
    tick(3);
    checks++;
    if (columnas_o !== 4'b0001) begin
      errors++;
      $display("FAIL reset_hold_div3: columnas_o=%b expected 0001", columnas_o);
    end
    tick(1);
    checks++;
    if (columnas_o !== 4'b0010) begin
      errors++;
      $display("FAIL reset_hold_scan: columnas_o=%b expected 0010", columnas_o);
    end
  endtask

  task automatic test_back_to_back();
    press(4'b0001, 2, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h3 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_key3: valid=%b code=%h ovr=%b expected 1 3 0", bus.valid, bus.codigo, bus.overrun);
    end
    release_key();
    press(4'b0100, 3, 1'b1);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'hC || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_keyC: valid=%b code=%h ovr=%b expected 1 c 0", bus.valid, bus.codigo, bus.overrun);
    end
    release_key();
    consume();
    press(4'b1000, 1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h0) begin
      errors++;
      $display("FAIL key0: valid=%b code=%h expected 1 0", bus.valid, bus.codigo);
    end
    // A second detect while held must not capture again.
    key_detect_i = 1'b1;
    tick(1);
    key_detect_i = 1'b0;
    tick(2);
    checks++;
    if (bus.valid !== 1'b1 || bus.codigo !== 4'h0 || bus.overrun !== 1'b0 || columnas_o !== 4'b0010) begin
      errors++;
      $display("FAIL detect_in_hold: valid=%b code=%h ovr=%b col=%b expected 1 0 0 0010",
               bus.valid, bus.codigo, bus.overrun, columnas_o);
    end
    release_key();
  endtask

  initial begin
    bus.ready = 1'b0;
    tick(1);
    test_reset();
    test_scan();
    test_key_latency();
    test_overrun();
    test_multi_row();
    test_reset_in_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
